// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, direct-mapped instruction cache and
// single-line refill engine feeding the IF/ID pipeline register.
module if_fetch_unit #(
  parameter int          INDEX_BITS      = 4,
  parameter int          LINE_WORDS_LOG2 = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] adder_out,
  output logic [31:0] instruction_out,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << LINE_WORDS_LOG2;
  localparam int IDX_LSB  = LINE_WORDS_LOG2 + 2;
  localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LSB;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t                       state_r;
  logic [31:0]                  pc_r;
  logic [LINE_WORDS_LOG2-1:0]   cnt_r;
  logic [INDEX_BITS-1:0]        ref_idx_r;
  logic [TAG_BITS-1:0]          ref_tag_r;
  logic                         mem_req_r;
  logic [31:0]                  mem_addr_r;
  logic [LINES-1:0]             valid_r;
  logic [TAG_BITS-1:0]          tag_r  [LINES];
  logic [31:0]                  data_r [LINES*WORDS];

  logic [LINE_WORDS_LOG2-1:0]   off_s;
  logic [INDEX_BITS-1:0]        idx_s;
  logic [TAG_BITS-1:0]          tag_s;
  logic                         lookup_hit_s;
  logic                         hit_s;
  logic                         last_beat_s;
  logic                         beat_s;

  assign off_s       = pc_r[IDX_LSB-1:2];
  assign idx_s       = pc_r[TAG_LSB-1:IDX_LSB];
  assign tag_s       = pc_r[31:TAG_LSB];
  assign last_beat_s = (cnt_r == {LINE_WORDS_LOG2{1'b1}});
  assign beat_s      = (state_r == REFILL) && mem_ready;

  // Cache lookup and fetch-valid qualification
  always_comb begin
    lookup_hit_s = 1'b0;
    hit_s        = 1'b0;
    if (state_r == IDLE && valid_r[idx_s] && tag_r[idx_s] == tag_s) begin
      lookup_hit_s = 1'b1;
    end else begin
      lookup_hit_s = 1'b0;
    end
    hit_s = lookup_hit_s && !stall && !redirect_valid;
  end

  // Output drive: instruction is forced to zero whenever it is not a capture
  always_comb begin
    instruction_out = 32'h0000_0000;
    if (hit_s) begin
      instruction_out = data_r[{idx_s, off_s}];
    end else begin
      instruction_out = 32'h0000_0000;
    end
  end

  assign hit       = hit_s;
  assign pc_out    = pc_r;
  assign adder_out = pc_r + 32'd4;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;

  // Program counter: redirect beats hit, otherwise hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= redirect_pc & 32'hFFFF_FFFC;
    end else if (hit_s) begin
      pc_r <= pc_r + 32'd4;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Refill FSM; a redirect never aborts an in-flight line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      ref_idx_r  <= '0;
      ref_tag_r  <= '0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      valid_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!lookup_hit_s && !redirect_valid) begin
            state_r    <= REFILL;
            cnt_r      <= '0;
            ref_idx_r  <= idx_s;
            ref_tag_r  <= tag_s;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {pc_r[31:IDX_LSB], {IDX_LSB{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt_r      <= cnt_r + LINE_WORDS_LOG2'(1);
            mem_addr_r <= mem_addr_r + 32'd4;
            if (last_beat_s) begin
              valid_r[ref_idx_r] <= 1'b1;
              state_r            <= IDLE;
              mem_req_r          <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (beat_s) begin
      data_r[{ref_idx_r, cnt_r}] <= mem_rdata;
      if (last_beat_s) begin
        tag_r[ref_idx_r] <= ref_tag_r;
      end
    end
  end

endmodule
